// File: rtl/obj_scan_unit_if.sv
// obj_scan_unit_if
// Bundles the two neighbour links of the object scan unit:
//   - lookup link: the scan unit pulses startrow/step toward the OAM lookup
//     stage and receives the attributes of the entry currently addressed.
//   - visible-object link: the scan unit presents the head of its visible
//     FIFO (vis_valid/vis_index/vis_dy) and the consumer removes it with vis_pop.
// Modports:
//   master : the scan unit side (drives startrow, step, vis_*; reads attributes, vis_pop)
//   slave  : the lookup stage / consumer side
interface obj_scan_unit_if;
  logic       startrow;
  logic       step;
  logic [7:0] objy;
  logic [7:0] vsize;
  logic       rotation;
  logic       dblsize;
  logic [1:0] objmode;
  logic       vis_valid;
  logic [6:0] vis_index;
  logic [6:0] vis_dy;
  logic       vis_pop;

  modport master (
    output startrow, step, vis_valid, vis_index, vis_dy,
    input  objy, vsize, rotation, dblsize, objmode, vis_pop
  );

  modport slave (
    input  startrow, step, vis_valid, vis_index, vis_dy,
    output objy, vsize, rotation, dblsize, objmode, vis_pop
  );
endinterface

// File: rtl/obj_scan_unit.sv
// obj_scan_unit
// Walks all NOBJ OAM entries once per scanline, decides which objects
// intersect the latched row, and queues {index, dy} of each visible object
// in ascending index order into a DEPTH-entry FIFO for the renderer.
// Each entry occupies two 32-bit lookup words, hence two step pulses per entry.
// Ports:
//   clock, reset   : system clock, synchronous active-high reset
//   linestart      : one-cycle pulse starting (or restarting) a scan
//   row            : scanline number, captured on linestart
//   scan_done      : last entry evaluated, held until next linestart
//   busy           : scan in progress (not IDLE / DONE)
//   bus (master)   : lookup link (startrow, step, attributes) and
//                    visible-object FIFO head (vis_valid, vis_index, vis_dy, vis_pop)
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | after reset, waiting for linestart
// START  | startrow pulse to the lookup stage, entry counter at 0
// WAIT   | ATTR_WAIT cycles for lookup attributes to settle
// EVAL   | visibility test of current entry, push if visible (may stall)
// STEP_A | first step pulse (first word of next entry)
// STEP_B | second step pulse, entry counter advances
// DONE   | all entries evaluated, scan_done held high
module obj_scan_unit #(
  parameter int NOBJ      = 128,
  parameter int DEPTH     = 16,
  parameter int ATTR_WAIT = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       linestart,
  input  logic [7:0] row,
  output logic       scan_done,
  output logic       busy,
  obj_scan_unit_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = (ATTR_WAIT > 1) ? $clog2(ATTR_WAIT) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    WAIT   = 3'd2,
    EVAL   = 3'd3,
    STEP_A = 3'd4,
    STEP_B = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    row_reg;
  logic [6:0]    entry;
  logic [WW-1:0] wait_cnt;

  logic          startrow_q;
  logic          step_q;
  logic          scan_done_q;
  logic          busy_q;

  logic [13:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic [8:0]    height;
  logic [7:0]    dy;
  logic          visible;
  logic          full;
  logic          not_empty;
  logic          pop_ok;
  logic          stall;
  logic          push;
  logic          last_entry;
  logic [13:0]   head;

  // Affine objects with the double-size flag cover twice their nominal
  // height; a non-affine object with that flag set is disabled instead.
  always_comb begin
    height = (bus.rotation && bus.dblsize) ? {bus.vsize, 1'b0} : {1'b0, bus.vsize};
  end

  // Modulo-256 difference lets objects wrapping past row 255 hit low rows.
  assign dy         = row_reg - bus.objy;
  assign visible    = ({1'b0, dy} < height)
                      && !(!bus.rotation && bus.dblsize)
                      && (bus.objmode != 2'd3);

  assign full       = (count == (AW+1)'(DEPTH));
  assign not_empty  = (count != '0);
  assign pop_ok     = bus.vis_pop && not_empty && !linestart;
  // A simultaneous pop frees the slot the push needs, so only a full FIFO
  // without a pop holds the scan.
  assign stall      = (state == EVAL) && visible && full && !bus.vis_pop;
  assign push       = (state == EVAL) && visible && !stall && !linestart;
  assign last_entry = (entry == 7'(NOBJ - 1));

  always_comb begin
    state_nxt = state;
    if (linestart) begin
      state_nxt = START;
    end else begin
      case (state)
        START:   state_nxt = WAIT;
        WAIT:    if (wait_cnt == '0) state_nxt = EVAL;
        EVAL:    if (!stall) state_nxt = last_entry ? DONE : STEP_A;
        STEP_A:  state_nxt = STEP_B;
        STEP_B:  state_nxt = WAIT;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      row_reg     <= '0;
      entry       <= '0;
      wait_cnt    <= '0;
      startrow_q  <= 1'b0;
      step_q      <= 1'b0;
      scan_done_q <= 1'b0;
      busy_q      <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      state <= state_nxt;

      // Outputs are decoded from the next state so they line up with it.
      startrow_q  <= (state_nxt == START);
      step_q      <= (state_nxt == STEP_A) || (state_nxt == STEP_B);
      scan_done_q <= (state_nxt == DONE);
      busy_q      <= (state_nxt != IDLE) && (state_nxt != DONE);

      if (state == START || state == STEP_B) begin
        wait_cnt <= WW'(ATTR_WAIT - 1);
      end else if (state == WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 1'b1;
      end

      if (state == STEP_B) begin
        entry <= entry + 7'd1;
      end

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // A new line discards whatever the previous scan left queued.
      if (linestart) begin
        row_reg <= row;
        entry   <= '0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {entry, dy[6:0]};
    end
  end

  assign head = mem[rd_ptr];

  assign bus.startrow  = startrow_q;
  assign bus.step      = step_q;
  assign bus.vis_valid = not_empty;
  // Head fields read as zero when empty so stale RAM never leaks out.
  assign bus.vis_index = not_empty ? head[13:7] : 7'd0;
  assign bus.vis_dy    = not_empty ? head[6:0]  : 7'd0;
  assign scan_done     = scan_done_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_obj_scan_unit.sv
module tb_obj_scan_unit;
  logic       clock = 1'b0;
  logic       reset;
  logic       linestart;
  logic [7:0] row;
  logic       scan_done;
  logic       busy;
  logic       vis_pop;

  obj_scan_unit_if bus();

  obj_scan_unit #(.NOBJ(128), .DEPTH(16), .ATTR_WAIT(1)) dut (
    .clock     (clock),
    .reset     (reset),
    .linestart (linestart),
    .row       (row),
    .scan_done (scan_done),
    .busy      (busy),
    .bus       (bus)
  );

  always #5 clock = ~clock;

  // Lookup-stage model: word pointer rewound by startrow, advanced by step;
  // entry attributes come from word pointer / 2.
  logic [7:0] tab_y    [128];
  logic [7:0] tab_v    [128];
  logic       tab_rot  [128];
  logic       tab_dbl  [128];
  logic [1:0] tab_mode [128];
  logic [7:0] ptr;

  always @(posedge clock) begin
    if (reset || bus.startrow) ptr <= 8'd0;
    else if (bus.step)         ptr <= ptr + 8'd1;
  end

  assign bus.objy     = tab_y[ptr[7:1]];
  assign bus.vsize    = tab_v[ptr[7:1]];
  assign bus.rotation = tab_rot[ptr[7:1]];
  assign bus.dblsize  = tab_dbl[ptr[7:1]];
  assign bus.objmode  = tab_mode[ptr[7:1]];
  assign bus.vis_pop  = vis_pop;

  int step_cnt = 0;
  int sr_cnt = 0;
  bit both_seen = 1'b0;
  always @(negedge clock) begin
    if (bus.step) step_cnt++;
    if (bus.startrow) sr_cnt++;
    if (bus.step && bus.startrow) both_seen = 1'b1;
  end

  int checks = 0;
  int errors = 0;
  logic [13:0] exp_q[$];
  int exp_n;
  int sr_base;
  int step_base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_dy(input int i, input int r);
    return (r - int'(tab_y[i]) + 256) % 256;
  endfunction

  function automatic bit model_vis(input int i, input int r);
    int h;
    int d;
    d = model_dy(i, r);
    h = (tab_rot[i] && tab_dbl[i]) ? 2 * int'(tab_v[i]) : int'(tab_v[i]);
    return (d < h) && !(!tab_rot[i] && tab_dbl[i]) && (tab_mode[i] != 2'd3);
  endfunction

  task automatic fill_default(input logic [7:0] y, input logic [7:0] v);
    for (int i = 0; i < 128; i++) begin
      tab_y[i] = y; tab_v[i] = v; tab_rot[i] = 1'b0; tab_dbl[i] = 1'b0; tab_mode[i] = 2'd0;
    end
  endtask

  task automatic load_expected(input int r);
    exp_q.delete();
    exp_n = 0;
    for (int i = 0; i < 128; i++) begin
      if (model_vis(i, r)) begin
        exp_q.push_back({7'(i), 7'(model_dy(i, r))});
        exp_n++;
      end
    end
  endtask

  task automatic start_line(input logic [7:0] r, input logic pop_with_ls);
    @(negedge clock);
    sr_base = sr_cnt;
    step_base = step_cnt;
    row = r;
    linestart = 1'b1;
    vis_pop = pop_with_ls;
    load_expected(int'(r));
    @(negedge clock);
    linestart = 1'b0;
    vis_pop = 1'b0;
    chk("ls_startrow", 32'(bus.startrow), 32'd1);
    chk("ls_flushed_valid", 32'(bus.vis_valid), 32'd0);
    chk("ls_busy", 32'(busy), 32'd1);
    chk("ls_scan_done_clr", 32'(scan_done), 32'd0);
  endtask

  // Pops every head as it appears and compares it with the scoreboard.
  task automatic drain(input int max_cyc);
    bit done;
    int n;
    logic [13:0] e;
    done = 1'b0;
    n = 0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      @(negedge clock);
      if (bus.vis_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_output", 32'(bus.vis_index), 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("vis_index", 32'(bus.vis_index), 32'(e[13:7]));
          chk("vis_dy", 32'(bus.vis_dy), 32'(e[6:0]));
        end
        n++;
        vis_pop = 1'b1;
      end else begin
        vis_pop = 1'b0;
        if (scan_done) done = 1'b1;
      end
    end
    vis_pop = 1'b0;
    chk("drain_timeout", 32'(done), 32'd1);
    chk("out_count", 32'(n), 32'(exp_n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] e;
    bit hit;
    reset = 1'b1; linestart = 1'b0; row = 8'd0; vis_pop = 1'b0;
    fill_default(8'd200, 8'd8);
    repeat (3) @(negedge clock);
    chk("rst_startrow", 32'(bus.startrow), 32'd0);
    chk("rst_step", 32'(bus.step), 32'd0);
    chk("rst_vis_valid", 32'(bus.vis_valid), 32'd0);
    chk("rst_vis_index", 32'(bus.vis_index), 32'd0);
    chk("rst_vis_dy", 32'(bus.vis_dy), 32'd0);
    chk("rst_scan_done", 32'(scan_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // Single visible entry, full scan, pulse counts.
    fill_default(8'd200, 8'd8);
    tab_y[5] = 8'd16;
    start_line(8'd20, 1'b0);
    drain(3000);
    chk("t1_step_pulses", 32'(step_cnt - step_base), 32'd254);
    chk("t1_startrow_pulses", 32'(sr_cnt - sr_base), 32'd1);
    chk("t1_scan_done", 32'(scan_done), 32'd1);
    chk("t1_busy_idle", 32'(busy), 32'd0);

    // Row wrap-around: dy=9 inside height 16; dy=8 at edge of height 8.
    fill_default(8'd200, 8'd8);
    tab_y[10] = 8'd250; tab_v[10] = 8'd16;
    tab_y[11] = 8'd250; tab_v[11] = 8'd8;
    start_line(8'd3, 1'b0);
    drain(3000);
    start_line(8'd2, 1'b0);
    drain(3000);

    // Affine double size, disabled object, prohibited mode.
    fill_default(8'd200, 8'd8);
    tab_y[20] = 8'd0; tab_v[20] = 8'd32; tab_rot[20] = 1'b1; tab_dbl[20] = 1'b1;
    tab_y[21] = 8'd0; tab_v[21] = 8'd32; tab_dbl[21] = 1'b1;
    tab_y[22] = 8'd0; tab_v[22] = 8'd64; tab_mode[22] = 2'd3;
    tab_y[23] = 8'd0; tab_v[23] = 8'd32;
    tab_y[24] = 8'd0; tab_v[24] = 8'd64; tab_rot[24] = 1'b1;
    start_line(8'd50, 1'b0);
    drain(3000);

    // Everything visible, no consumer: FIFO fills and the scan stalls.
    fill_default(8'd0, 8'd200);
    start_line(8'd100, 1'b0);
    repeat (300) @(negedge clock);
    chk("stall_steps", 32'(step_cnt - step_base), 32'd32);
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_not_done", 32'(scan_done), 32'd0);
    repeat (20) @(negedge clock);
    chk("stall_steps_held", 32'(step_cnt - step_base), 32'd32);
    e = exp_q.pop_front();
    exp_n--;
    chk("stall_head_index", 32'(bus.vis_index), 32'(e[13:7]));
    chk("stall_head_dy", 32'(bus.vis_dy), 32'(e[6:0]));
    vis_pop = 1'b1;
    @(negedge clock);
    vis_pop = 1'b0;
    chk("stall_pop_valid", 32'(bus.vis_valid), 32'd1);
    chk("stall_pop_next_head", 32'(bus.vis_index), 32'(exp_q[0][13:7]));
    repeat (5) @(negedge clock);
    chk("stall_resume_steps", 32'(step_cnt - step_base), 32'd34);
    drain(3000);

    // Abort mid-scan with three objects queued.
    fill_default(8'd200, 8'd4);
    for (int i = 0; i < 3; i++) tab_y[i] = 8'd10;
    tab_y[50] = 8'd28; tab_v[50] = 8'd8;
    tab_y[60] = 8'd28; tab_v[60] = 8'd8;
    start_line(8'd10, 1'b0);
    hit = 1'b0;
    for (int c = 0; c < 1000 && !hit; c++) begin
      @(negedge clock);
      if (step_cnt - step_base >= 80) hit = 1'b1;
    end
    chk("abort_reach_entry40", 32'(hit), 32'd1);
    @(negedge clock);
    chk("abort_pre_valid", 32'(bus.vis_valid), 32'd1);
    chk("abort_pre_head", 32'(bus.vis_index), 32'd0);
    start_line(8'd30, 1'b1);
    drain(3000);
    chk("abort_startrow_pulses", 32'(sr_cnt - sr_base), 32'd1);

    // Reset while stepping with a non-empty FIFO.
    fill_default(8'd200, 8'd8);
    tab_y[0] = 8'd5;
    start_line(8'd6, 1'b0);
    hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge clock);
      if (bus.step) hit = 1'b1;
    end
    chk("r38_in_step", 32'(hit), 32'd1);
    chk("r38_fifo_nonempty", 32'(bus.vis_valid), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("r38_startrow", 32'(bus.startrow), 32'd0);
    chk("r38_step", 32'(bus.step), 32'd0);
    chk("r38_vis_valid", 32'(bus.vis_valid), 32'd0);
    chk("r38_vis_index", 32'(bus.vis_index), 32'd0);
    chk("r38_vis_dy", 32'(bus.vis_dy), 32'd0);
    chk("r38_scan_done", 32'(scan_done), 32'd0);
    chk("r38_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    chk("step_startrow_exclusive", 32'(both_seen), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/obj_scan_unit.md
OBJ_SCAN_UNIT -- requirements
Module: obj_scan_unit

Interface
REQ-001 Parameter: NOBJ, 128, number of OAM entries scanned per line (index width 7 bits).
REQ-002 Parameter: DEPTH, 16, visible-object FIFO depth (power of two, 2..64).
REQ-003 Parameter: ATTR_WAIT, 1, cycles between last step pulse and attributes becoming stable from the lookup stage.
REQ-004 clock  in  1  single system clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 linestart  in  1  one-cycle pulse that begins the scan for a new scanline.
REQ-007 row  in  8  current scanline number, sampled on linestart.
REQ-008 objy, vsize  in  8 each  Y position and height of the current entry from the lookup stage.
REQ-009 rotation, dblsize  in  1 each  affine flag and double-size/disable flag from the lookup stage.
REQ-010 objmode  in  2  object mode from the lookup stage; 3 is prohibited.
REQ-011 startrow, step  out  1 each  control pulses to the lookup stage (rewind to entry 0; advance one 32-bit word).
REQ-012 vis_valid  out  1  FIFO head holds a visible object.
REQ-013 vis_index  out  7  OAM index of the head object.
REQ-014 vis_dy  out  7  row offset inside the object, (row - objy) mod 256, low 7 bits.
REQ-015 vis_pop  in  1  consumer removes head; ignored when vis_valid=0.
REQ-016 scan_done  out  1  high from completion of entry NOBJ-1 evaluation until the next linestart or reset.
REQ-017 busy  out  1  high in every state except IDLE and DONE.

Function
REQ-018 States: IDLE, START, WAIT, EVAL, STEP_A, STEP_B, DONE.
REQ-019 IDLE/DONE + linestart -> START; START drives startrow=1 for exactly one cycle, latches row into an 8-bit register, clears entry counter to 0, then -> WAIT.
REQ-020 WAIT holds ATTR_WAIT cycles (counter), step=0, startrow=0, then -> EVAL.
REQ-021 EVAL: height h (9 bits) = vsize doubled when rotation=1 and dblsize=1, else vsize; dy = (row_reg - objy) mod 256 (8 bits); visible iff {1'b0,dy} < h and not (rotation=0 and dblsize=1) and objmode != 3.
REQ-022 EVAL, visible, FIFO full and no vis_pop this cycle -> stay in EVAL (stall; no step, no push).
REQ-023 EVAL otherwise: push {index, dy[6:0]} if visible; then entry=NOBJ-1 -> DONE, else -> STEP_A.
REQ-024 STEP_A and STEP_B each drive step=1 for one cycle (two words per entry); STEP_B increments entry counter and -> WAIT.
REQ-025 step and startrow are never both 1; both 0 in IDLE, WAIT, EVAL, DONE.
REQ-026 FIFO: push and pop in same cycle allowed when full or non-empty; count unchanged; push to empty with no pop makes vis_valid=1 next cycle (no bypass).
REQ-027 FIFO order is ascending OAM index; pointers wrap modulo DEPTH; count width log2(DEPTH)+1.
REQ-028 linestart in any state other than IDLE/DONE aborts: FIFO flushed (count=0) in the same edge, -> START; pending pop that cycle ignored.
REQ-029 linestart while FIFO non-empty in DONE also flushes.
REQ-030 scan_done clears on the edge that enters START.

Reset
REQ-031 reset (sync, priority over all inputs) -> state IDLE, entry=0, row_reg=0, FIFO count and pointers 0.
REQ-032 Outputs after reset: startrow=0, step=0, vis_valid=0, vis_index=0, vis_dy=0, scan_done=0, busy=0.

Verification
REQ-033 row=20, entry 5 objy=16 vsize=8 others objy=200 vsize=8, mode 0 -> one push {5,4}; startrow 1 pulse; 2*(NOBJ-1) step pulses total; scan_done set.
REQ-034 row=3, objy=250, vsize=16 -> dy=9, visible; objy=250, vsize=8, row=2 -> dy=8, not visible.
REQ-035 rotation=1 dblsize=1 vsize=32 objy=0 row=50 -> visible dy=50; rotation=0 dblsize=1 same values -> not visible; objmode=3 -> not visible.
REQ-036 all 128 entries visible, DEPTH=16, no pops -> stall in EVAL at entry 16, no step; single vis_pop -> entry 16 pushed same cycle, scan resumes.
REQ-037 linestart mid-scan at entry 40 with 3 queued -> vis_valid=0 next cycle, startrow pulse, rescan from entry 0 with new row.
REQ-038 reset asserted in STEP_A with FIFO non-empty -> all outputs at reset values next cycle.
